// File: rtl/rtc_bus_wr_rd.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bus_wr_rd
// Description : Multiplexed address/data bus sequencer for one RTC register
//               write or read per request, with a one-cycle Final_WR pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bus_wr_rd #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_wr,
  input  logic       wr_rd,
  input  logic [7:0] addr_in,
  input  logic [7:0] data_in,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic [7:0] data_rd,
  output logic       busy,
  output logic       Final_WR
);

  localparam logic [7:0] C_PULSE_LAST = 8'(T_PULSE - 1);
  localparam logic [7:0] C_GAP_LAST   = 8'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR_PH  = 3'd1,
    S_ADDR_GAP = 3'd2,
    S_DATA_PH  = 3'd3,
    S_DATA_GAP = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       bus_oe_q, bus_oe_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       ad_sel_q, ad_sel_d;
  logic       busy_q, busy_d;
  logic       fin_q, fin_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      is_wr_q   <= 1'b0;
      addr_q    <= 8'd0;
      wdata_q   <= 8'd0;
      rdata_q   <= 8'd0;
      bus_out_q <= 8'd0;
      bus_oe_q  <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      ad_sel_q  <= 1'b1;
      busy_q    <= 1'b0;
      fin_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_out_q <= bus_out_d;
      bus_oe_q  <= bus_oe_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      ad_sel_q  <= ad_sel_d;
      busy_q    <= busy_d;
      fin_q     <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          state_d = S_ADDR_PH;
          is_wr_d = wr_rd;
          addr_d  = addr_in;
          wdata_d = data_in;
        end
      end
      S_ADDR_PH:  if (cnt_q == C_PULSE_LAST) state_d = S_ADDR_GAP;
      S_ADDR_GAP: if (cnt_q == C_GAP_LAST)   state_d = S_DATA_PH;
      S_DATA_PH: begin
        // Capture on the edge that ends the strobe, while rd_n is still low.
        if (cnt_q == C_PULSE_LAST) begin
          state_d = S_DATA_GAP;
          if (!is_wr_q) rdata_d = bus_in;
        end
      end
      S_DATA_GAP: if (cnt_q == C_GAP_LAST) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (state_d != state_q || state_q == S_IDLE || state_q == S_DONE) cnt_d = 8'd0;
    else                                                              cnt_d = cnt_q + 8'd1;

    // Outputs are decoded from the next state so they register in step with it.
    bus_out_d = 8'd0;
    bus_oe_d  = 1'b0;
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    ad_sel_d  = 1'b1;
    fin_d     = 1'b0;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_ADDR_PH: begin
        cs_n_d = 1'b0; wr_n_d = 1'b0; ad_sel_d = 1'b0;
        bus_out_d = addr_d; bus_oe_d = 1'b1;
      end
      S_ADDR_GAP: begin
        ad_sel_d = 1'b0; bus_out_d = addr_d; bus_oe_d = 1'b1;
      end
      S_DATA_PH: begin
        cs_n_d = 1'b0;
        if (is_wr_d) begin
          wr_n_d = 1'b0; bus_out_d = wdata_d; bus_oe_d = 1'b1;
        end else begin
          rd_n_d = 1'b0;
        end
      end
      S_DATA_GAP: begin
        if (is_wr_d) begin
          bus_out_d = wdata_d; bus_oe_d = 1'b1;
        end
      end
      S_DONE:  fin_d = 1'b1;
      default: ;
    endcase
  end

  assign bus_out  = bus_out_q;
  assign bus_oe   = bus_oe_q;
  assign cs_n     = cs_n_q;
  assign rd_n     = rd_n_q;
  assign wr_n     = wr_n_q;
  assign ad_sel   = ad_sel_q;
  assign data_rd  = rdata_q;
  assign busy     = busy_q;
  assign Final_WR = fin_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_bus_wr_rd.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_bus_wr_rd
// Description : Directed self-checking bench for rtc_bus_wr_rd (T_PULSE=4, T_GAP=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_bus_wr_rd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_wr = 1'b0;
  logic       wr_rd = 1'b0;
  logic [7:0] addr_in = 8'd0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] bus_in = 8'd0;
  logic [7:0] bus_out;
  logic       bus_oe, cs_n, rd_n, wr_n, ad_sel, busy, Final_WR;
  logic [7:0] data_rd;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  // {cs_n, rd_n, wr_n, ad_sel, bus_oe, busy, Final_WR}
  localparam logic [6:0] C_IDLE = 7'b1111000;

  rtc_bus_wr_rd #(.T_PULSE(4), .T_GAP(2)) dut (
    .clk(clk), .reset(reset), .start_wr(start_wr), .wr_rd(wr_rd),
    .addr_in(addr_in), .data_in(data_in), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .cs_n(cs_n), .rd_n(rd_n),
    .wr_n(wr_n), .ad_sel(ad_sel), .data_rd(data_rd), .busy(busy),
    .Final_WR(Final_WR)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_ctrl(input int c, input bit wr);
    if (c < 4)       return 7'b0100110;
    else if (c < 6)  return 7'b1110110;
    else if (c < 10) return wr ? 7'b0101110 : 7'b0011010;
    else if (c < 12) return wr ? 7'b1111110 : 7'b1111010;
    else if (c == 12) return 7'b1111011;
    else             return C_IDLE;
  endfunction

  always @(negedge clk) begin
    if (mon_en) check_eq("no_contention", {31'd0, bus_oe & ~rd_n}, 32'd0);
  end

  // One full transaction from an IDLE start; inputs are scrambled right after
  // acceptance and bus_in carries rdv only in the last DATA_PH cycle.
  task automatic do_txn(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] rdv, input logic [7:0] exp_rd);
    logic [6:0] e;
    @(negedge clk);
    start_wr = 1'b1; wr_rd = wr; addr_in = a; data_in = d; bus_in = ~rdv;
    for (int c = 0; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start_wr = 1'b0; wr_rd = ~wr; addr_in = ~a; data_in = ~d;
      end
      e = exp_ctrl(c, wr);
      check_eq($sformatf("ctrl wr=%0d c=%0d", wr, c),
               {25'd0, cs_n, rd_n, wr_n, ad_sel, bus_oe, busy, Final_WR}, {25'd0, e});
      if (c < 6)
        check_eq($sformatf("bus_out_addr c=%0d", c), {24'd0, bus_out}, {24'd0, a});
      else if (wr && c < 12)
        check_eq($sformatf("bus_out_data c=%0d", c), {24'd0, bus_out}, {24'd0, d});
      if (c >= 12)
        check_eq($sformatf("data_rd c=%0d", c), {24'd0, data_rd}, {24'd0, exp_rd});
      bus_in = (c == 9) ? rdv : ~rdv;
    end
  endtask

  initial begin
    int fin_cnt;
    #3 reset = 1'b0;
    #1;
    check_eq("reset_ctrl", {25'd0, cs_n, rd_n, wr_n, ad_sel, bus_oe, busy, Final_WR}, {25'd0, C_IDLE});
    check_eq("reset_bus_out", {24'd0, bus_out}, 32'd0);
    check_eq("reset_data_rd", {24'd0, data_rd}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;

    do_txn(1'b1, 8'h21, 8'h15, 8'h3C, 8'h00);
    do_txn(1'b0, 8'h23, 8'h00, 8'hA5, 8'hA5);
    do_txn(1'b1, 8'h5A, 8'hC3, 8'h77, 8'hA5);
    do_txn(1'b0, 8'h0F, 8'hFF, 8'h00, 8'h00);

    // start_wr held high through edge n+27: exactly two back-to-back writes.
    fin_cnt = 0;
    @(negedge clk);
    start_wr = 1'b1; wr_rd = 1'b1; addr_in = 8'h44; data_in = 8'h99;
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk); #1;
      if (Final_WR) fin_cnt++;
      check_eq($sformatf("held_fin c=%0d", c), {31'd0, Final_WR}, {31'd0, (c == 12 || c == 26)});
      check_eq($sformatf("held_busy c=%0d", c), {31'd0, busy},
               {31'd0, (c <= 12 || (c >= 14 && c <= 26))});
      if (c == 13) check_eq("held_cs_idle", {31'd0, cs_n}, 32'd1);
      if (c == 14) check_eq("held_cs_second", {31'd0, cs_n}, 32'd0);
      if (c == 27) start_wr = 1'b0;
    end
    check_eq("held_fin_count", fin_cnt, 2);

    // Asynchronous reset in the middle of a write's DATA_PH.
    @(negedge clk);
    start_wr = 1'b1; wr_rd = 1'b1; addr_in = 8'h66; data_in = 8'h81;
    @(posedge clk); #1;
    start_wr = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
    end
    check_eq("abort_in_data_ph", {30'd0, cs_n, wr_n}, 32'd0);
    #1 reset = 1'b0;
    #1;
    check_eq("abort_ctrl", {25'd0, cs_n, rd_n, wr_n, ad_sel, bus_oe, busy, Final_WR}, {25'd0, C_IDLE});
    check_eq("abort_bus_out", {24'd0, bus_out}, 32'd0);
    check_eq("abort_data_rd", {24'd0, data_rd}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_eq($sformatf("abort_no_fin c=%0d", c), {31'd0, Final_WR}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    do_txn(1'b1, 8'h12, 8'hE7, 8'h55, 8'h00);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
